// File: rtl/knn_result_stream_if.sv
// Valid/ready beat stream carrying one classified query per transfer.
interface knn_result_stream_if #(
  parameter int QUERY_DATA_POINTS = 4,
  parameter int CLASSIFICATIONS   = 4
);
  localparam int CW = (CLASSIFICATIONS > 1) ? $clog2(CLASSIFICATIONS) : 1;
  localparam int IW = $clog2(QUERY_DATA_POINTS + 1);

  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_index;
  logic [CW-1:0] out_class;
  logic          out_match;
  logic          out_last;

  modport master (
    output out_valid, out_index, out_class, out_match, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_index, out_class, out_match, out_last,
    output out_ready
  );
endinterface

// File: rtl/knn_result_stream.sv
// Snapshots KNN labels on a done rising edge and streams them one query per beat,
// flagging matches against ground truth and tallying accepted matches.
module knn_result_stream #(
  parameter int   QUERY_DATA_POINTS = 4,
  parameter int   CLASSIFICATIONS   = 4,
  localparam int  CW = (CLASSIFICATIONS > 1) ? $clog2(CLASSIFICATIONS) : 1,
  localparam int  IW = $clog2(QUERY_DATA_POINTS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 knn_done,
  input  logic [CW-1:0]        classif  [QUERY_DATA_POINTS],
  input  logic [CW-1:0]        expected [QUERY_DATA_POINTS],
  knn_result_stream_if.master  beat,
  output logic [IW-1:0]        correct_count,
  output logic                 busy,
  output logic                 done
);

  localparam logic [IW-1:0] LAST_IDX = IW'(QUERY_DATA_POINTS - 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FINISHED
  } state_t;

  state_t state, state_next;

  logic                         knn_done_q;
  logic [IW-1:0]                idx;
  logic [CW-1:0]                cap_class [QUERY_DATA_POINTS];
  logic [QUERY_DATA_POINTS-1:0] cap_match;

  logic start;
  logic capture;
  logic accept;
  logic is_last;
  logic cur_match;

  assign start     = knn_done & ~knn_done_q;
  assign capture   = (state == IDLE) & start;
  assign accept    = (state == STREAM) & beat.out_ready;
  assign is_last   = (idx == LAST_IDX);
  assign cur_match = cap_match[idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (start)           state_next = STREAM;
      STREAM:   if (accept && is_last) state_next = FINISHED;
      FINISHED: if (!knn_done)       state_next = IDLE;
      default:                       state_next = IDLE;
    endcase
  end

  // Match bits are resolved at capture time, so only labels and one flag per query are held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      knn_done_q    <= 1'b0;
      idx           <= '0;
      correct_count <= '0;
      cap_class     <= '{default: '0};
      cap_match     <= '0;
    end else begin
      knn_done_q <= knn_done;
      if (capture) begin
        for (int unsigned i = 0; i < unsigned'(QUERY_DATA_POINTS); i++) begin
          cap_class[i] <= classif[i];
          cap_match[i] <= (classif[i] == expected[i]);
        end
        idx           <= '0;
        correct_count <= '0;
      end else if (accept) begin
        correct_count <= correct_count + IW'(cur_match);
        if (!is_last) begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  assign busy = (state == STREAM);
  assign done = (state == FINISHED);

  // Beat fields are driven from registers and forced to zero outside the streaming state.
  assign beat.out_valid = busy;
  assign beat.out_index = busy ? idx : '0;
  assign beat.out_class = busy ? cap_class[idx] : '0;
  assign beat.out_match = busy & cur_match;
  assign beat.out_last  = busy & is_last;

endmodule

// File: tb/tb_knn_result_stream.sv
// Scoreboard-driven bench for knn_result_stream: runs, stalls, live-input changes,
// retrigger after a done pulse and asynchronous reset mid-stream.
module tb_knn_result_stream;
  localparam int QDP = 4;
  localparam int NC  = 4;
  localparam int CW  = 2;
  localparam int IW  = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          knn_done;
  logic [CW-1:0] classif  [QDP];
  logic [CW-1:0] expected [QDP];
  logic [IW-1:0] correct_count;
  logic          busy;
  logic          done;

  knn_result_stream_if #(.QUERY_DATA_POINTS(QDP), .CLASSIFICATIONS(NC)) beat_if ();

  knn_result_stream #(.QUERY_DATA_POINTS(QDP), .CLASSIFICATIONS(NC)) dut (
    .clk           (clk),
    .reset         (reset),
    .knn_done      (knn_done),
    .classif       (classif),
    .expected      (expected),
    .beat          (beat_if.master),
    .correct_count (correct_count),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int cls;
    bit match;
    bit last;
  } beat_t;

  beat_t sb[$];
  int    exp_count;
  int    errors = 0;
  int    checks = 0;

  task automatic load_run(input int c[QDP], input int e[QDP]);
    exp_count = 0;
    for (int i = 0; i < QDP; i++) begin
      beat_t b;
      classif[i]  = CW'(c[i]);
      expected[i] = CW'(e[i]);
      b.idx   = i;
      b.cls   = c[i];
      b.match = (c[i] == e[i]);
      b.last  = (i == QDP - 1);
      sb.push_back(b);
      if (b.match) exp_count++;
    end
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1,0,0 repeating;
  // mode 2: ready high, knn_done dropped and live classif scrambled after the first acceptance.
  task automatic stream_run(input int mode, input string tag);
    int    cyc = 0;
    int    acc = 0;
    int    running = 0;
    bit    stalled = 0;
    bit    finished = 0;
    bit    dropped = 0;
    beat_t held;
    beat_t ex;
    while (!finished && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (mode == 2 && acc == 1 && !dropped) begin
        knn_done = 1'b0;
        for (int i = 0; i < QDP; i++) classif[i] = 2'd3;
        dropped = 1;
      end
      beat_if.out_ready = (mode == 1) ? ((cyc - 1) % 3 == 0) : 1'b1;
      if (done) begin
        checks++;
        if (beat_if.out_valid !== 1'b0) begin
          errors++; $display("FAIL %s done_valid: got %b want 0", tag, beat_if.out_valid);
        end
        checks++;
        if (correct_count !== IW'(exp_count)) begin
          errors++; $display("FAIL %s final_count: got %0d want %0d", tag, correct_count, exp_count);
        end
        checks++;
        if (sb.size() != 0 || acc != QDP) begin
          errors++; $display("FAIL %s beats_accepted: got %0d want %0d", tag, acc, QDP);
        end
        if (mode != 1) begin
          checks++;
          if (cyc - 1 != acc) begin
            errors++; $display("FAIL %s throughput: got %0d cycles want %0d", tag, cyc - 1, acc);
          end
        end
        finished = 1;
      end else if (beat_if.out_valid === 1'b1) begin
        checks++;
        if (busy !== 1'b1 || correct_count !== IW'(running)) begin
          errors++;
          $display("FAIL %s running_count: got busy=%b count=%0d want busy=1 count=%0d",
                   tag, busy, correct_count, running);
        end
        if (stalled) begin
          checks++;
          if (beat_if.out_index !== IW'(held.idx) || beat_if.out_class !== CW'(held.cls) ||
              beat_if.out_match !== held.match || beat_if.out_last !== held.last) begin
            errors++;
            $display("FAIL %s stall_stable: got idx=%0d cls=%0d m=%b l=%b want idx=%0d cls=%0d m=%b l=%b",
                     tag, beat_if.out_index, beat_if.out_class, beat_if.out_match, beat_if.out_last,
                     held.idx, held.cls, held.match, held.last);
          end
        end
        if (beat_if.out_ready) begin
          checks++;
          if (sb.size() == 0) begin
            errors++; $display("FAIL %s extra_beat: got idx=%0d want no beat", tag, beat_if.out_index);
          end else begin
            ex = sb.pop_front();
            if (beat_if.out_index !== IW'(ex.idx) || beat_if.out_class !== CW'(ex.cls) ||
                beat_if.out_match !== ex.match || beat_if.out_last !== ex.last) begin
              errors++;
              $display("FAIL %s beat: got idx=%0d cls=%0d m=%b l=%b want idx=%0d cls=%0d m=%b l=%b",
                       tag, beat_if.out_index, beat_if.out_class, beat_if.out_match, beat_if.out_last,
                       ex.idx, ex.cls, ex.match, ex.last);
            end
            if (ex.match) running++;
          end
          acc++;
          stalled = 0;
        end else begin
          stalled    = 1;
          held.idx   = int'(beat_if.out_index);
          held.cls   = int'(beat_if.out_class);
          held.match = beat_if.out_match;
          held.last  = beat_if.out_last;
        end
      end else begin
        checks++;
        errors++;
        $display("FAIL %s idle_gap: got valid=%b done=%b want one of them high", tag, beat_if.out_valid, done);
      end
    end
    if (!finished) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got no done within 40 cycles want done", tag);
    end
  endtask

  // Drop knn_done for one edge (DONE -> IDLE), then raise it with a new label set.
  task automatic retrigger(input int c[QDP], input int e[QDP], input int prev_count, input string tag);
    @(negedge clk);
    knn_done = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || correct_count !== IW'(prev_count)) begin
      errors++;
      $display("FAIL %s idle_hold: got done=%b busy=%b count=%0d want 0 0 %0d",
               tag, done, busy, correct_count, prev_count);
    end
    load_run(c, e);
    knn_done = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    knn_done = 1'b0;
    beat_if.out_ready = 1'b0;
    for (int i = 0; i < QDP; i++) begin
      classif[i]  = '0;
      expected[i] = '0;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (beat_if.out_valid !== 1'b0 || beat_if.out_index !== '0 || beat_if.out_class !== '0 ||
        beat_if.out_match !== 1'b0 || beat_if.out_last !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || correct_count !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b i=%0d c=%0d m=%b l=%b busy=%b done=%b cnt=%0d want all 0",
               beat_if.out_valid, beat_if.out_index, beat_if.out_class, beat_if.out_match,
               beat_if.out_last, busy, done, correct_count);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || beat_if.out_valid !== 1'b0) begin
      errors++; $display("FAIL idle_no_start: got busy=%b done=%b valid=%b want 0 0 0",
                         busy, done, beat_if.out_valid);
    end
  endtask

  task automatic test_match_all();
    load_run('{0, 1, 2, 3}, '{0, 1, 2, 3});
    knn_done = 1'b1;
    stream_run(0, "match_all");
  endtask

  task automatic test_mismatch();
    retrigger('{3, 1, 0, 2}, '{3, 2, 0, 1}, 4, "mismatch");
    stream_run(0, "mismatch");
  endtask

  task automatic test_stall();
    retrigger('{3, 1, 0, 2}, '{3, 2, 0, 1}, 2, "stall");
    stream_run(1, "stall");
  endtask

  task automatic test_done_drop();
    retrigger('{1, 2, 3, 0}, '{1, 0, 3, 0}, 2, "done_drop");
    stream_run(2, "done_drop");
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL done_drop_idle: got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    load_run('{0, 0, 0, 0}, '{0, 0, 0, 0});
    knn_done = 1'b1;
    stream_run(0, "held_run");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || correct_count !== IW'(4)) begin
        errors++; $display("FAIL held_done: got done=%b busy=%b cnt=%0d want 1 0 4", done, busy, correct_count);
      end
    end
    retrigger('{2, 2, 1, 1}, '{2, 0, 1, 3}, 4, "pulse");
    stream_run(0, "pulse_run");
  endtask

  task automatic test_reset_mid();
    bit hit = 0;
    retrigger('{1, 1, 1, 1}, '{1, 1, 1, 1}, 2, "reset_mid");
    for (int k = 0; k < 10 && !hit; k++) begin
      @(negedge clk);
      beat_if.out_ready = 1'b1;
      if (beat_if.out_valid === 1'b1 && beat_if.out_index === IW'(2)) hit = 1;
    end
    checks++;
    if (!hit) begin
      errors++; $display("FAIL reset_mid_reach: got no beat at index 2 want index 2");
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (beat_if.out_valid !== 1'b0 || beat_if.out_index !== '0 || beat_if.out_class !== '0 ||
        beat_if.out_match !== 1'b0 || beat_if.out_last !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || correct_count !== '0) begin
      errors++;
      $display("FAIL reset_async: got v=%b i=%0d busy=%b done=%b cnt=%0d want all 0",
               beat_if.out_valid, beat_if.out_index, busy, done, correct_count);
    end
    sb.delete();
    @(negedge clk);
    load_run('{3, 2, 1, 0}, '{3, 2, 1, 1});
    reset = 1'b1;
    stream_run(0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_match_all();
    test_mismatch();
    test_stall();
    test_done_drop();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion want finish before 100000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/knn_result_stream.md
Name: knn_result_stream

Overview:
Downstream consumer of the KNN top-level's `classif` array and `done` flag. When a classification run completes, the block snapshots all per-query labels and the expected (ground-truth) labels. It then serializes them one query per beat over a valid/ready stream, flagging each beat as match or mismatch, and tallies the number of correct classifications. This gives the design an accuracy readout and a narrow output path in place of the wide parallel `classif` bus.

Parameters:
QUERY_DATA_POINTS, 4, number of query points (entries in `classif`/`expected`); must be >=1
CLASSIFICATIONS, 4, number of classes; label width CW = $clog2(CLASSIFICATIONS)

Ports:
clk  input  1  single clock; all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
knn_done  input  1  KNN completion flag; level, may stay high indefinitely
classif  input  [CW-1:0] x QUERY_DATA_POINTS (unpacked)  per-query labels from KNN; valid while knn_done=1
expected  input  [CW-1:0] x QUERY_DATA_POINTS (unpacked)  ground-truth labels; sampled together with classif
out_valid  output  1  beat available
out_ready  input  1  downstream accepts beat
out_index  output  $clog2(QUERY_DATA_POINTS+1)  query index of current beat
out_class  output  CW  captured classif[out_index]
out_match  output  1  1 when captured classif == captured expected at out_index
out_last  output  1  1 on the beat with out_index == QUERY_DATA_POINTS-1
correct_count  output  $clog2(QUERY_DATA_POINTS+1)  running/final count of matching beats accepted
busy  output  1  1 in STREAM state
done  output  1  1 in DONE state

Behaviour:
- Reset (reset==0, async): state=IDLE; knn_done_q=0; idx=0; correct_count=0; capture registers=0. Outputs out_valid, out_index, out_class, out_match, out_last, busy and done are all 0.
- Rising-edge detect: start = knn_done & ~knn_done_q, with knn_done_q registered every cycle. If knn_done is already high when reset releases, the first clock counts as a start.
- IDLE: on start, capture all classif[] and expected[], clear correct_count to 0, set idx=0, go to STREAM. Otherwise hold; correct_count keeps its previous run's value.
- STREAM: out_valid=1 and busy=1. out_index=idx; out_class and out_match come from the capture registers; out_last=(idx==QUERY_DATA_POINTS-1). All beat outputs are registered and change only on acceptance.
  - Handshake: a beat is accepted when out_valid & out_ready are both high in the same cycle.
  - While out_ready=0, all beat outputs stay stable.
  - On acceptance: correct_count += out_match. If out_last, go to DONE; otherwise idx+1.
  - Throughput is 1 beat/cycle with out_ready held high.
- Latency: a start sampled at clock edge N gives out_valid=1 after edge N; the first beat can be accepted at edge N+1. The last acceptance is at edge N+QUERY_DATA_POINTS with no stalls, and DONE follows that edge.
- DONE: done=1, out_valid=0, correct_count is final.
  - Leave for IDLE when knn_done==0. If knn_done is already 0 on DONE entry, done is high for exactly one cycle.
  - While knn_done stays 1, remain in DONE; no re-trigger without a fall followed by a rise.
- knn_done falls during STREAM: ignored. The stream completes from the captured copy, since live classif/expected are not read after capture.
- knn_done rise during STREAM or DONE: not captured and not queued; the event is dropped.
- reset asserted mid-STREAM: immediate abort to the reset values above; the partial count is lost.
- QUERY_DATA_POINTS=1: single beat with out_last=1, then DONE.
- correct_count never exceeds QUERY_DATA_POINTS; no wrap is possible by width choice.

Test Plan:
- Reset then knn_done=1 with classif={0,1,2,3} and expected={0,1,2,3}, out_ready=1 -> 4 beats on consecutive cycles (index 0..3, out_match all 1, out_last only on index 3); correct_count=4; done high.
- classif={3,1,0,2}, expected={3,2,0,1}, out_ready=1 -> out_match sequence 1,0,1,0; correct_count=2 at DONE.
- Same run with out_ready toggling 1,0,0,1,... -> no beat dropped or duplicated; outputs stable during stalls; total 4 accepted beats; correct_count matches the unstalled run.
- knn_done drops after the 1st beat and classif changes to all 3 -> remaining beats still show the captured values; done asserts; FSM returns to IDLE the cycle after DONE since knn_done=0.
- knn_done held high through DONE, then pulsed low for 1 cycle and high again with new labels -> second run starts; correct_count clears to 0 on capture, then counts the new run.
- reset pulled low while out_index=2 -> all outputs 0 immediately (asynchronous); after release with knn_done=1, a fresh run starts from index 0.
